// File: rtl/apb_master_seq.sv
// Single-outstanding APB master: valid/ready command in, IDLE->SETUP->ACCESS out, one-cycle response strobe.
// Optional ACCESS wait limit is compiled in with `define APB_TIMEOUT_EN (default build waits indefinitely).
`timescale 1ns/1ps
module apb_master_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                accept;
  logic                done_ok;
  logic                tmo;

  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign done_ok = (state_q == S_ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Abort fires on the ACCESS cycle that would be the TIMEOUT-th one without PREADY.
  assign tmo = (state_q == S_ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if ((state_q == S_ACCESS) && !PREADY)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (done_ok || tmo) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    PENABLE   = (state_q == S_ACCESS);
    PSEL      = 8'h00;
    if ((state_q == S_SETUP) || (state_q == S_ACCESS))
      PSEL = 8'h01 << idx_q;
  end

  // Command fields are held from acceptance until the next command.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        idx_q    <= cmd_addr[SEL_LSB+2:SEL_LSB];
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
      if (done_ok) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
        rsp_err_q   <= PSLVERR;
      end else if (tmo) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_seq.sv
// Scoreboard bench for apb_master_seq: stimulus pushes expected transfers, a negedge monitor checks APB phases and responses.
`timescale 1ns/1ps
module tb_apb_master_seq;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 12;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [7:0]    PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  apb_master_seq #(.ADDR_W(AW), .DATA_W(DW), .SEL_LSB(SL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    logic          perr;
    logic [7:0]    psel;
    int            waits;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            lat;
    int            t_hs;
  } txn_t;

  txn_t exp_q[$];
  txn_t mt;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   acc = 0;
  logic prev_act = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Slave model: follows the wait count of the transfer at the head of the scoreboard.
  always @(negedge CLK) begin
    if (PENABLE && (PSEL != 8'h00) && (exp_q.size() > 0)) begin
      if (acc >= exp_q[0].waits) begin
        PREADY  = 1'b1;
        PSLVERR = exp_q[0].perr;
        PRDATA  = exp_q[0].prdata;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'hBAD0_0000 + acc;
      end
      acc++;
    end else begin
      acc     = 0;
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'b1;
      PRDATA  = 32'hFFFF_FFFF;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      prev_act = 1'b0;
    end else begin
      if (PSEL != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("psel_unexpected", {56'd0, PSEL}, 64'd0);
        end else begin
          check("psel", {56'd0, PSEL}, {56'd0, exp_q[0].psel});
          check("penable_phase", {63'd0, PENABLE}, {63'd0, prev_act});
          check("paddr", {32'd0, PADDR}, {32'd0, exp_q[0].addr});
          check("pwrite", {63'd0, PWRITE}, {63'd0, exp_q[0].wr});
          check("pwdata", {32'd0, PWDATA}, {32'd0, exp_q[0].wdata});
        end
        prev_act = 1'b1;
      end else begin
        if (PENABLE) check("penable_idle", {63'd0, PENABLE}, 64'd0);
        prev_act = 1'b0;
      end
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
        end else begin
          mt = exp_q.pop_front();
          check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mt.exp_rdata});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, mt.exp_err});
          check("rsp_latency", 64'(cyc - mt.t_hs), 64'(mt.lat));
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] prd, input logic perr, output int t_hs);
    txn_t t;
    int   n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b0;
      t_hs = -1;
      return;
    end
    t.wr        = wr;
    t.addr      = addr;
    t.wdata     = wdata;
    t.prdata    = prd;
    t.perr      = perr;
    t.psel      = 8'd1 << addr[SL+2:SL];
    t.waits     = waits;
    t.exp_rdata = wr ? '0 : prd;
    t.exp_err   = perr;
    t.lat       = 3 + waits;
`ifdef APB_TIMEOUT_EN
    if (waits >= TO) begin
      t.lat       = 2 + TO;
      t.exp_err   = 1'b1;
      t.exp_rdata = '0;
    end
`endif
    t.t_hs = cyc;
    t_hs   = cyc;
    exp_q.push_back(t);
    @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, r0;
    repeat (3) @(negedge CLK);
    check("rst_psel", {56'd0, PSEL}, 64'd0);
    check("rst_penable", {63'd0, PENABLE}, 64'd0);
    check("rst_pwrite", {63'd0, PWRITE}, 64'd0);
    check("rst_paddr", {32'd0, PADDR}, 64'd0);
    check("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b0, 32'h0000_4000, 32'h0, 3, 32'h1234_5678, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b0, 32'h0000_7000, 32'h0, 0, 32'hCAFE_F00D, 1'b1, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b1, 32'h0000_3008, 32'h5555_AAAA, 2, 32'h7777_7777, 1'b1, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0BAD_F00D, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b0, 32'hFFFF_D123, 32'h0, 1, 32'h8000_0001, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
    send(1'b0, 32'h0000_6000, 32'h0, TO - 1, 32'h0F0F_0F0F, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();

    send(1'b1, 32'h0000_2000, 32'h1111_2222, 0, 32'h0, 1'b0, t1);
    send(1'b0, 32'h0000_5000, 32'h3333_4444, 1, 32'hA5A5_5A5A, 1'b0, t2);
    send(1'b1, 32'h0000_1000, 32'h9999_0000, 0, 32'h0, 1'b0, t3);
    cmd_valid = 1'b0;
    check("b2b_spacing_1", 64'(t2 - t1), 64'd3);
    check("b2b_spacing_2", 64'(t3 - t2), 64'd4);
    drain();

    r0 = rsp_seen;
    send(1'b0, 32'h0000_3000, 32'h0, 5, 32'h1357_9BDF, 1'b0, t1);
    cmd_valid = 1'b0;
    @(negedge CLK);
    check("pre_rst_penable", {63'd0, PENABLE}, 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_psel", {56'd0, PSEL}, 64'd0);
    check("midrst_penable", {63'd0, PENABLE}, 64'd0);
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    exp_q.delete();
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (8) @(negedge CLK);
    check("midrst_no_rsp", 64'(rsp_seen), 64'(r0));

    send(1'b0, 32'h0000_5000, 32'h0, 1000, 32'h2468_ACE0, 1'b0, t1);
    cmd_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
    drain();
    send(1'b1, 32'h0000_2004, 32'h4242_4242, 0, 32'h0, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
`else
    r0 = rsp_seen;
    repeat (100) @(negedge CLK);
    check("stuck_no_rsp", 64'(rsp_seen), 64'(r0));
    check("stuck_penable", {63'd0, PENABLE}, 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    RST = 1'b0;
    @(negedge CLK);
    send(1'b1, 32'h0000_2004, 32'h4242_4242, 0, 32'h0, 1'b0, t1);
    cmd_valid = 1'b0;
    drain();
`endif
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
